bus_master_if: RTL and testbench

- Master-side bus interface unit; converts a single-cycle core access request into the shared-bus transaction sequence: request, grant, address strobe, ready.
- One instance per bus master (m0..m3) of the shared bus. Sits between a core pipeline stage and the bus arbiter/master mux.
- Returns read data, stalls the core via busy, and aborts hung slave accesses with a watchdog.

---
 rtl/bus_master_if_pkg.sv | 20 ++
 rtl/bus_if_watchdog.sv | 29 ++
 rtl/bus_master_if.sv | 127 ++++++++++++
 tb/tb_bus_master_if.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_master_if_pkg.sv
// Shared definitions for the bus master interface: state encoding, bus polarity
// constants and word bus widths.
package bus_master_if_pkg;

  localparam int unsigned WORD_ADDR_W = 30;
  localparam int unsigned WORD_DATA_W = 32;

  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef enum logic [1:0] {
    BUS_IF_IDLE,
    BUS_IF_REQ,
    BUS_IF_ACCESS,
    BUS_IF_HOLD
  } bus_if_state_e;

endpackage

// File: rtl/bus_if_watchdog.sv
// Hung-access watchdog: counts enabled cycles since the last clear and flags the
// cycle that would reach TIMEOUT. A TIMEOUT of 0 never fires.
module bus_if_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned LAST  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

  // tc covers the current cycle, so the abort lands on the TIMEOUT-th idle cycle.
  assign tc = (TIMEOUT != 0) && en && (cnt == CNT_W'(LAST));

endmodule

// File: rtl/bus_master_if.sv
// Master-side bus interface: turns a one-cycle core access into a
// request/grant/strobe/ready bus transaction and stalls the core meanwhile.
module bus_master_if
  import bus_master_if_pkg::*;
#(
  parameter int unsigned        ADDR_W   = WORD_ADDR_W,
  parameter int unsigned        DATA_W   = WORD_DATA_W,
  parameter int unsigned        TIMEOUT  = 255,
  parameter logic [DATA_W-1:0]  ERR_DATA = DATA_W'(32'hDEAD_BEEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] addr,
  input  logic              as_,
  input  logic              rw,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              err,
  output logic              bus_req_,
  input  logic              bus_grnt_,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_
);

  bus_if_state_e     state;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_rw;
  logic [DATA_W-1:0] lat_wr_data;
  logic [DATA_W-1:0] rd_buf;
  logic              wd_clr;
  logic              wd_en;
  logic              wd_tc;

  assign wd_clr = (state != BUS_IF_ACCESS);
  assign wd_en  = (state == BUS_IF_ACCESS) && (bus_rdy_ == DISABLE_);

  bus_if_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk  (clk),
    .reset(reset),
    .clr  (wd_clr),
    .en   (wd_en),
    .tc   (wd_tc)
  );

  assign rd_data = rd_buf;

  always_comb begin
    busy = 1'b0;
    case (state)
      BUS_IF_IDLE:                busy = (as_ == ENABLE_) && !flush;
      BUS_IF_REQ, BUS_IF_ACCESS:  busy = 1'b1;
      default:                    busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= BUS_IF_IDLE;
      bus_req_    <= DISABLE_;
      bus_as_     <= DISABLE_;
      bus_rw      <= READ;
      bus_addr    <= '0;
      bus_wr_data <= '0;
      lat_addr    <= '0;
      lat_rw      <= READ;
      lat_wr_data <= '0;
      rd_buf      <= '0;
      err         <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        BUS_IF_IDLE: begin
          if (as_ == ENABLE_ && !flush) begin
            lat_addr    <= addr;
            lat_rw      <= rw;
            lat_wr_data <= wr_data;
            bus_req_    <= ENABLE_;
            state       <= BUS_IF_REQ;
          end
        end
        BUS_IF_REQ: begin
          if (flush) begin
            bus_req_ <= DISABLE_;
            state    <= BUS_IF_IDLE;
          end else if (bus_grnt_ == ENABLE_) begin
            bus_as_     <= ENABLE_;
            bus_addr    <= lat_addr;
            bus_rw      <= lat_rw;
            bus_wr_data <= lat_wr_data;
            state       <= BUS_IF_ACCESS;
          end
        end
        BUS_IF_ACCESS: begin
          bus_as_ <= DISABLE_;
          // wd_tc is gated by bus_rdy_ being idle, so a late ready still wins.
          if (bus_rdy_ == ENABLE_ || wd_tc) begin
            if (bus_rdy_ == ENABLE_) begin
              if (bus_rw == READ) rd_buf <= bus_rd_data;
            end else begin
              rd_buf <= ERR_DATA;
              err    <= 1'b1;
            end
            bus_req_    <= DISABLE_;
            bus_addr    <= '0;
            bus_rw      <= READ;
            bus_wr_data <= '0;
            state       <= stall ? BUS_IF_HOLD : BUS_IF_IDLE;
          end
        end
        BUS_IF_HOLD: begin
          if (!stall) state <= BUS_IF_IDLE;
        end
        default: state <= BUS_IF_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_if.sv
// Bench for bus_master_if: emulates core, arbiter and slave; checks a vector table,
// random transactions against a latency/result model, and flush/reset corner cases.
module tb_bus_master_if;
  import bus_master_if_pkg::*;

  localparam int unsigned TO   = 4;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset, stall, flush, as_, rw, busy, err;
  logic [29:0] addr, bus_addr;
  logic [31:0] wr_data, rd_data, bus_wr_data, bus_rd_data;
  logic        bus_req_, bus_grnt_, bus_as_, bus_rw, bus_rdy_;

  bus_master_if #(
    .ADDR_W  (30),
    .DATA_W  (32),
    .TIMEOUT (TO),
    .ERR_DATA(ERRD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .addr       (addr),
    .as_        (as_),
    .rw         (rw),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .busy       (busy),
    .err        (err),
    .bus_req_   (bus_req_),
    .bus_grnt_  (bus_grnt_),
    .bus_addr   (bus_addr),
    .bus_as_    (bus_as_),
    .bus_rw     (bus_rw),
    .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data),
    .bus_rdy_   (bus_rdy_)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model_rd;

  typedef struct {
    logic        rw;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gdel;
    int          swait;
    int          stall_n;
    logic [31:0] exp_rd;
    int          exp_done;
    logic        exp_err;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Expected result from the protocol rules: REQ lasts gdel+1 cycles, ACCESS lasts
  // until ready or TO idle cycles, and rd_data keeps its value across writes.
  task automatic mk_rand(output vec_t v);
    int len;
    v.rw      = 1'($urandom_range(0, 1));
    v.addr    = 30'($urandom);
    v.wdata   = $urandom;
    v.rdata   = $urandom;
    v.gdel    = $urandom_range(0, 4);
    v.swait   = $urandom_range(0, 6);
    v.stall_n = $urandom_range(0, 3);
    v.exp_err = (v.swait + 1 > TO);
    len       = v.exp_err ? TO : v.swait + 1;
    v.exp_done = 2 + v.gdel + len;
    v.exp_rd  = v.exp_err ? ERRD : (v.rw ? v.rdata : model_rd);
  endtask

  task automatic run_txn(input vec_t v);
    int          t, req_cnt, acc_cnt, as_cnt, err_cnt, viol, done;
    logic        in_acc;
    logic [29:0] as_addr;
    logic        as_rw;
    logic [31:0] as_wd;
    t = 1; req_cnt = 0; acc_cnt = 0; as_cnt = 0; err_cnt = 0; viol = 0; done = 0;
    in_acc = 1'b0; as_addr = '0; as_rw = 1'b0; as_wd = '0;
    as_ = 1'b0; addr = v.addr; rw = v.rw; wr_data = v.wdata;
    stall = (v.stall_n > 0); flush = 1'b0; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
    bus_rd_data = $urandom;
    #1 check("busy_on_accept", busy, 1);
    next_cycle();
    // Scramble core inputs so only the latched copy can reach the bus.
    as_ = 1'b1; addr = 30'($urandom); wr_data = $urandom; rw = ~v.rw;
    while (done == 0 && t < 60) begin
      if (bus_req_) in_acc = 1'b0;
      if (bus_as_ == 1'b0) begin
        if (bus_req_) viol++;
        in_acc = 1'b1; acc_cnt = 1; as_cnt++;
        as_addr = bus_addr; as_rw = bus_rw; as_wd = bus_wr_data;
      end else if (in_acc) begin
        acc_cnt++;
        if (bus_addr !== v.addr || bus_rw !== v.rw || bus_wr_data !== v.wdata) viol++;
      end else if (bus_addr !== '0 || bus_rw !== 1'b1 || bus_wr_data !== '0) begin
        viol++;
      end
      if (in_acc) bus_grnt_ = 1'b0;
      else if (!bus_req_) begin
        req_cnt++;
        bus_grnt_ = (req_cnt > v.gdel) ? 1'b0 : 1'b1;
      end else bus_grnt_ = 1'b1;
      bus_rdy_    = (in_acc && acc_cnt == v.swait + 1) ? 1'b0 : 1'b1;
      bus_rd_data = bus_rdy_ ? $urandom : v.rdata;
      if (err) err_cnt++;
      #1;
      if (!busy) done = t;
      else begin
        next_cycle();
        t++;
      end
    end
    check("as_count", as_cnt, 1);
    check("as_addr", as_addr, v.addr);
    check("as_rw", as_rw, v.rw);
    check("as_wr_data", as_wd, v.wdata);
    check("req_wait", req_cnt, v.gdel + 1);
    check("done_cycle", done, v.exp_done);
    check("err_pulse", err_cnt, v.exp_err);
    check("bus_idle_viol", viol, 0);
    check("rd_data", rd_data, v.exp_rd);
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
    for (int h = 0; h < v.stall_n; h++) begin
      next_cycle();
      stall = (h < v.stall_n - 1);
      as_   = 1'b0;
      addr  = 30'($urandom);
      #1;
      check("hold_rd_data", rd_data, v.exp_rd);
      check("hold_busy", busy, 0);
      check("hold_no_accept", bus_req_, 1);
    end
    next_cycle();
    as_ = 1'b1; stall = 1'b0;
    #1;
    check("gap_req", bus_req_, 1);
    check("err_cleared", err, 0);
    check("idle_busy", busy, 0);
    next_cycle();
    model_rd = v.exp_rd;
  endtask

  initial begin
    vec_t v;
    reset = 1'b0; stall = 1'b0; flush = 1'b0; as_ = 1'b1; rw = 1'b1;
    addr = '0; wr_data = '0; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = '0;
    model_rd = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("rst_bus_req", bus_req_, 1);
    check("rst_bus_as", bus_as_, 1);
    check("rst_bus_rw", bus_rw, 1);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", bus_wr_data, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    next_cycle();

    tbl[0] = '{rw: 1'b1, addr: 30'h100, wdata: 32'h0, rdata: 32'h1234_5678, gdel: 0, swait: 0,
               stall_n: 0, exp_rd: 32'h1234_5678, exp_done: 3, exp_err: 1'b0};
    tbl[1] = '{rw: 1'b0, addr: 30'h200, wdata: 32'hA5A5_0001, rdata: 32'h5555_5555, gdel: 5,
               swait: 0, stall_n: 0, exp_rd: 32'h1234_5678, exp_done: 8, exp_err: 1'b0};
    tbl[2] = '{rw: 1'b1, addr: 30'h3FFF_FFFF, wdata: 32'h1, rdata: 32'hCAFE_F00D, gdel: 1,
               swait: 3, stall_n: 0, exp_rd: 32'hCAFE_F00D, exp_done: 7, exp_err: 1'b0};
    tbl[3] = '{rw: 1'b1, addr: 30'h10, wdata: 32'h2, rdata: 32'h7777_7777, gdel: 0, swait: 9,
               stall_n: 0, exp_rd: ERRD, exp_done: 6, exp_err: 1'b1};
    tbl[4] = '{rw: 1'b1, addr: 30'h20, wdata: 32'h3, rdata: 32'h0BAD_F00D, gdel: 2, swait: 2,
               stall_n: 3, exp_rd: 32'h0BAD_F00D, exp_done: 7, exp_err: 1'b0};
    tbl[5] = '{rw: 1'b0, addr: 30'h30, wdata: 32'h4, rdata: 32'h8888_8888, gdel: 0, swait: 9,
               stall_n: 0, exp_rd: ERRD, exp_done: 6, exp_err: 1'b1};
    tbl[6] = '{rw: 1'b0, addr: 30'h40, wdata: 32'h5, rdata: 32'h9999_9999, gdel: 0, swait: 1,
               stall_n: 2, exp_rd: ERRD, exp_done: 4, exp_err: 1'b0};
    for (int i = 0; i < 7; i++) run_txn(tbl[i]);

    // Flush in REQ beats a simultaneous grant.
    as_ = 1'b0; addr = 30'h55; rw = 1'b1; wr_data = 32'h0;
    next_cycle();
    as_ = 1'b1; flush = 1'b1; bus_grnt_ = 1'b0;
    #1;
    check("flush_req_busy", busy, 1);
    check("flush_req_low", bus_req_, 0);
    next_cycle();
    flush = 1'b0; bus_grnt_ = 1'b1;
    #1;
    check("flush_req_released", bus_req_, 1);
    check("flush_no_strobe", bus_as_, 1);
    check("flush_idle_busy", busy, 0);
    check("flush_no_err", err, 0);
    check("flush_rd_kept", rd_data, model_rd);
    next_cycle();
    check("flush_no_strobe_late", bus_as_, 1);
    // Flush in IDLE suppresses acceptance.
    as_ = 1'b0; flush = 1'b1;
    #1 check("flush_idle_busy_comb", busy, 0);
    next_cycle();
    as_ = 1'b1; flush = 1'b0;
    #1 check("flush_idle_no_req", bus_req_, 1);
    next_cycle();

    for (int i = 0; i < 40; i++) begin
      mk_rand(v);
      run_txn(v);
    end

    // Reset while ACCESS is in progress.
    as_ = 1'b0; addr = 30'h77; rw = 1'b1; wr_data = 32'h0;
    next_cycle();
    as_ = 1'b1; bus_grnt_ = 1'b0;
    next_cycle();
    check("rst_mid_in_access", bus_as_, 0);
    reset = 1'b0;
    next_cycle();
    reset = 1'b1; bus_grnt_ = 1'b1;
    #1;
    check("rst_mid_req", bus_req_, 1);
    check("rst_mid_as", bus_as_, 1);
    check("rst_mid_addr", bus_addr, 0);
    check("rst_mid_rd_data", rd_data, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_err", err, 0);
    next_cycle();
    check("rst_mid_stays_idle", bus_req_, 1);
    model_rd = '0;

    mk_rand(v);
    run_txn(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
